// File: rtl/baud_rate_gen_if.sv
// Control and tick bundle for baud_rate_gen.
// The master side sets the divisor and controls run and restart; the slave side returns the ticks and status.
interface baud_rate_gen_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned OSR    = 16
);
    logic                    en;
    logic [DIV_W-1:0]        div_int;
    logic [FRAC_W-1:0]       div_frac;
    logic                    load;
    logic                    resync;
    logic                    os_tick;
    logic                    baud_tick;
    logic [$clog2(OSR)-1:0]  os_phase;
    logic                    cfg_err;

    modport master (
        output en, div_int, div_frac, load, resync,
        input  os_tick, baud_tick, os_phase, cfg_err
    );

    modport slave (
        input  en, div_int, div_frac, load, resync,
        output os_tick, baud_tick, os_phase, cfg_err
    );
endinterface

// File: rtl/baud_rate_gen.sv
// Fractional baud-rate generator: one os_tick per oversample period and one baud_tick per OSR ticks.
// The divisor is int + frac/2^FRAC_W clk. Each period lasts act_int or act_int+1 cycles.
module baud_rate_gen #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OSR      = 16,
    parameter int unsigned DEF_INT  = 325,
    parameter int unsigned DEF_FRAC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    baud_rate_gen_if.slave   bus
);
    localparam int unsigned PH_W = $clog2(OSR);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [DIV_W-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              ext_q, ext_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              os_tick_q, os_tick_d;
    logic              baud_tick_q, baud_tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic              load_ok;
    logic              period_end;
    logic [DIV_W-1:0]  end_cnt;
    logic [FRAC_W:0]   acc_sum;

    always_comb begin
        load_ok    = bus.load && (bus.div_int >= DIV_W'(2));
        end_cnt    = act_int_q - DIV_W'(1) + DIV_W'(ext_q);
        period_end = bus.en && (cnt_q == end_cnt);
        acc_sum    = {1'b0, acc_q} + {1'b0, act_frac_q};
    end

    // Shadow divisor and sticky error. An illegal load leaves the shadow unchanged.
    always_comb begin
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        cfg_err_d  = cfg_err_q;
        if (bus.load) begin
            if (load_ok) begin
                shd_int_d  = bus.div_int;
                shd_frac_d = bus.div_frac;
                cfg_err_d  = 1'b0;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end
    end

    // Period sequencing. Priority is: disabled, then restart, then period end, then count.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ext_d       = ext_q;
        phase_d     = phase_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        os_tick_d   = 1'b0;
        baud_tick_d = 1'b0;

        if (!bus.en) begin
            cnt_d      = '0;
            acc_d      = '0;
            ext_d      = 1'b0;
            phase_d    = '0;
            act_int_d  = shd_int_q;
            act_frac_d = shd_frac_q;
        end else if (bus.resync) begin
            // A load in the same cycle must govern the restarted period, so use the next shadow.
            cnt_d      = '0;
            acc_d      = '0;
            ext_d      = 1'b0;
            phase_d    = '0;
            act_int_d  = shd_int_d;
            act_frac_d = shd_frac_d;
        end else if (period_end) begin
            cnt_d       = '0;
            acc_d       = acc_sum[FRAC_W-1:0];
            ext_d       = acc_sum[FRAC_W];
            phase_d     = phase_q + PH_W'(1);
            os_tick_d   = 1'b1;
            baud_tick_d = (phase_q == PH_W'(OSR - 1));
            act_int_d   = shd_int_q;
            act_frac_d  = shd_frac_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            ext_q       <= 1'b0;
            phase_q     <= '0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            act_int_q   <= DIV_W'(DEF_INT);
            shd_int_q   <= DIV_W'(DEF_INT);
            act_frac_q  <= FRAC_W'(DEF_FRAC);
            shd_frac_q  <= FRAC_W'(DEF_FRAC);
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ext_q       <= ext_d;
            phase_q     <= phase_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
            cfg_err_q   <= cfg_err_d;
            act_int_q   <= act_int_d;
            shd_int_q   <= shd_int_d;
            act_frac_q  <= act_frac_d;
            shd_frac_q  <= shd_frac_d;
        end
    end

    assign bus.os_tick   = os_tick_q;
    assign bus.baud_tick = baud_tick_q;
    assign bus.os_phase  = phase_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: doc/baud_rate_gen.md
BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4, width of the fractional divisor (units of 1/2^FRAC_W clk).
REQ-003 SHALL have parameter OSR, default 16, oversample ratio (power of two, >=2).
REQ-004 SHALL have parameters DEF_INT, default 325, and DEF_FRAC, default 8, reset divisor (50 MHz / (9600*16)).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-006 SHALL have port en  in  1  run enable.
REQ-007 SHALL have port div_int  in  DIV_W  requested integer divisor in clk cycles.
REQ-008 SHALL have port div_frac  in  FRAC_W  requested fractional divisor.
REQ-009 SHALL have port load  in  1  single-cycle request to capture div_int/div_frac.
REQ-010 SHALL have port resync  in  1  single-cycle request to restart phase (RX start-bit alignment).
REQ-011 SHALL have port os_tick  out  1  one-cycle pulse per oversample period.
REQ-012 SHALL have port baud_tick  out  1  one-cycle pulse per bit period.
REQ-013 SHALL have port os_phase  out  log2(OSR)  index of the current oversample slot.
REQ-014 SHALL have port cfg_err  out  1  sticky flag: last load was illegal.

Function
REQ-015 SHALL keep active divisor registers act_int/act_frac, counter cnt (DIV_W), fraction accumulator acc (FRAC_W), extend flag ext, and os_phase.
REQ-016 SHALL increment cnt on each clk edge with en=1; when cnt == act_int-1+ext, it SHALL set cnt to 0 and assert os_tick (registered) for exactly the following cycle.
REQ-017 SHALL, at each period end, compute {carry,acc} = acc + act_frac and set ext = carry for the next period only.
REQ-018 SHALL therefore make 2^FRAC_W consecutive periods total exactly 2^FRAC_W*act_int + act_frac cycles, with each period being act_int or act_int+1.
REQ-019 SHALL increment os_phase modulo OSR at each os_tick; baud_tick SHALL assert in the same cycle as the os_tick whose period end wraps os_phase from OSR-1 to 0.
REQ-020 SHALL place the first os_tick after en rises exactly act_int cycles after the first edge sampling en=1, and the first baud_tick on the OSR-th os_tick.
REQ-021 SHALL, with en=0, hold cnt, acc, ext and os_phase at 0 and drive os_tick and baud_tick at 0.
REQ-022 SHALL treat load with div_int < 2 as illegal: cfg_err set to 1 and divisors unchanged.
REQ-023 SHALL capture a legal load into shadow registers and clear cfg_err; the shadow SHALL become active at the next period end, or on the next edge if en=0.
REQ-024 SHALL, on resync with en=1, clear cnt, acc, ext and os_phase on that edge with no tick that cycle; the next os_tick SHALL occur act_int cycles later.
REQ-025 SHALL, on resync and legal load in the same cycle, apply the new divisor immediately to the restarted period.
REQ-026 SHALL let the last load win when a second load arrives before the shadow is applied.
REQ-027 SHALL give en=0 priority over resync and over period end.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously, including mid-period), force cnt=0, acc=0, ext=0, os_phase=0, os_tick=0, baud_tick=0, cfg_err=0, act_int=shadow=DEF_INT and act_frac=shadow=DEF_FRAC.
REQ-029 SHALL, after rst_n deasserts, give the first os_tick DEF_INT cycles after the first edge sampling en=1.

Verification
REQ-030 SHALL cover: load div_int=4, div_frac=0, en=1 -> os_tick every 4 clk, baud_tick every 64 clk coincident with os_phase wrap to 0.
REQ-031 SHALL cover: div_int=4, div_frac=8 -> os_tick intervals alternate 4,5; 16 intervals total 72 clk.
REQ-032 SHALL cover: load div_int=8 mid-period while running at 4 -> current period completes at 4, following periods are 8.
REQ-033 SHALL cover: load div_int=1 -> cfg_err=1 and rate unchanged; then load div_int=6 -> cfg_err=0 and period 6.
REQ-034 SHALL cover: resync at cnt=2 (div 4, os_phase=5) -> os_phase=0, next os_tick 4 clk later, baud_tick after 16 more os_ticks.
REQ-035 SHALL cover: rst_n low mid-period -> all outputs 0 immediately without a clock; after release with en=1, first os_tick at 325 clk.
